// File: rtl/l2_nway_control.sv
// l2_nway_control: N-way set-associative write-back L2 controller FSM.
// Keeps per-set valid/dirty/tree-PLRU state and drives the L2 datapath arrays.
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   mem_read/mem_write  CPU request, held until resp; set_in = request set
//   cmp                 per-way tag match from the datapath
//   resp                one-cycle request completion
//   set_out/way_sel     array set index / way on the read port
//   data_in_sel         0 = CPU write data, 1 = cacheline fill data
//   write_en/load_tag   one-hot data write / tag load enables
//   cacheline_read/write/resp  line fill / write-back handshake
// Optional: define L2_FLUSH_EN to turn mem_read&mem_write into a full flush.
module l2_nway_control #(
    parameter int WAYS = 4,
    parameter int SETS = 8,
    localparam int WW = $clog2(WAYS),
    localparam int SW = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [SW-1:0] set_in,
    input  logic [WAYS-1:0] cmp,
    output logic          resp,
    output logic [SW-1:0] set_out,
    output logic [WW-1:0] way_sel,
    output logic          data_in_sel,
    output logic [WAYS-1:0] write_en,
    output logic [WAYS-1:0] load_tag,
    output logic          cacheline_read,
    output logic          cacheline_write,
    input  logic          cacheline_resp
);

    typedef enum logic [2:0] {
        IDLE, WRITE_BACK, TAG_UPD, READ_MEM, FILL_DONE,
        FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];
    logic [WW-1:0]   victim_q;
    logic [SW-1:0]   set_q;

    logic [WAYS-1:0] vld_s, drt_s, hit_vec;
    logic            hit;
    logic [WW-1:0]   hit_way, inv_way, miss_victim;

`ifdef L2_FLUSH_EN
    logic [SW+WW-1:0] f_cnt;
    logic [SW-1:0]    f_set;
    logic [WW-1:0]    f_way;
    assign f_set = f_cnt[SW+WW-1:WW];
    assign f_way = f_cnt[WW-1:0];
`endif

    // Walk the heap from the root; each bit says which half holds the victim.
    function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] p);
        int idx;
        logic [WW-1:0] w;
        idx = 0;
        w = '0;
        for (int l = 0; l < WW; l++) begin
            w = (w << 1) | WW'(p[idx]);
            idx = 2 * idx + 1 + int'(p[idx]);
        end
        return w;
    endfunction

    // Point every node on the touched way's path away from it.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                   input logic [WW-1:0] w);
        logic [WAYS-2:0] r;
        logic b;
        int idx;
        r = p;
        idx = 0;
        for (int l = 0; l < WW; l++) begin
            b = w[WW-1-l];
            r[idx] = ~b;
            idx = 2 * idx + 1 + int'(b);
        end
        return r;
    endfunction

    function automatic logic [WAYS-1:0] onehot(input logic [WW-1:0] w);
        return WAYS'(1) << w;
    endfunction

    assign vld_s   = valid_q[set_in];
    assign drt_s   = dirty_q[set_in];
    assign hit_vec = cmp & vld_s;
    assign hit     = |hit_vec;

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WW'(i);
            if (!vld_s[i])  inv_way = WW'(i);
        end
    end

    assign miss_victim = (&vld_s) ? plru_victim(plru_q[set_in]) : inv_way;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        resp            = 1'b0;
        set_out         = set_in;
        way_sel         = '0;
        data_in_sel     = 1'b0;
        write_en        = '0;
        load_tag        = '0;
        cacheline_read  = 1'b0;
        cacheline_write = 1'b0;
        case (state_q)
            IDLE: begin
                way_sel = hit_way;
                if (mem_read && mem_write) begin
`ifdef L2_FLUSH_EN
                    state_d = FLUSH_SCAN;
`else
                    state_d = IDLE;
`endif
                end else if (mem_read || mem_write) begin
                    if (hit) begin
                        resp = 1'b1;
                        if (mem_write) write_en = onehot(hit_way);
                    end else if (vld_s[miss_victim] && drt_s[miss_victim]) begin
                        state_d = WRITE_BACK;
                    end else begin
                        state_d = TAG_UPD;
                    end
                end
            end
            WRITE_BACK: begin
                way_sel         = victim_q;
                cacheline_write = 1'b1;
                if (cacheline_resp) state_d = TAG_UPD;
            end
            TAG_UPD: begin
                way_sel  = victim_q;
                load_tag = onehot(victim_q);
                state_d  = READ_MEM;
            end
            READ_MEM: begin
                way_sel        = victim_q;
                data_in_sel    = 1'b1;
                write_en       = onehot(victim_q);
                cacheline_read = 1'b1;
                if (cacheline_resp) state_d = FILL_DONE;
            end
            FILL_DONE: begin
                way_sel = victim_q;
                resp    = 1'b1;
                if (mem_write) write_en = onehot(victim_q);
                state_d = IDLE;
            end
`ifdef L2_FLUSH_EN
            FLUSH_SCAN: begin
                set_out = f_set;
                way_sel = f_way;
                if (valid_q[f_set][f_way] && dirty_q[f_set][f_way])
                    state_d = FLUSH_WB;
                else if (&f_cnt)
                    state_d = FLUSH_DONE;
            end
            FLUSH_WB: begin
                set_out         = f_set;
                way_sel         = f_way;
                cacheline_write = 1'b1;
                if (cacheline_resp)
                    state_d = (&f_cnt) ? FLUSH_DONE : FLUSH_SCAN;
            end
            FLUSH_DONE: begin
                resp    = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        // Outputs are quiet for the whole reset cycle, whatever the state.
        if (!rst_n) begin
            resp            = 1'b0;
            set_out         = '0;
            way_sel         = '0;
            data_in_sel     = 1'b0;
            write_en        = '0;
            load_tag        = '0;
            cacheline_read  = 1'b0;
            cacheline_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            victim_q <= '0;
            set_q    <= '0;
`ifdef L2_FLUSH_EN
            f_cnt    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read ^ mem_write) begin
                        if (hit) begin
                            plru_q[set_in] <= plru_touch(plru_q[set_in], hit_way);
                            if (mem_write) dirty_q[set_in][hit_way] <= 1'b1;
                        end else begin
                            victim_q <= miss_victim;
                            set_q    <= set_in;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (cacheline_resp) dirty_q[set_q][victim_q] <= 1'b0;
                end
                TAG_UPD: begin
                    valid_q[set_q][victim_q] <= 1'b1;
                    dirty_q[set_q][victim_q] <= 1'b0;
                end
                FILL_DONE: begin
                    plru_q[set_q] <= plru_touch(plru_q[set_q], victim_q);
                    if (mem_write) dirty_q[set_q][victim_q] <= 1'b1;
                end
`ifdef L2_FLUSH_EN
                FLUSH_SCAN: begin
                    if (!(valid_q[f_set][f_way] && dirty_q[f_set][f_way]))
                        f_cnt <= f_cnt + 1'b1;
                end
                FLUSH_WB: begin
                    if (cacheline_resp) begin
                        dirty_q[f_set][f_way] <= 1'b0;
                        f_cnt <= f_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_nway_control.sv
// tb_l2_nway_control: directed bench for l2_nway_control (WAYS=4, SETS=8).
// Drives CPU, datapath cmp and cacheline adaptor by hand; checks with assertions.
module tb_l2_nway_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic [2:0] set_in = '0;
    logic [3:0] cmp = '0;
    logic       cacheline_resp = 1'b0;
    logic       resp;
    logic [2:0] set_out;
    logic [1:0] way_sel;
    logic       data_in_sel;
    logic [3:0] write_en;
    logic [3:0] load_tag;
    logic       cacheline_read;
    logic       cacheline_write;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    l2_nway_control #(.WAYS(4), .SETS(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .set_in(set_in),
        .cmp(cmp),
        .resp(resp),
        .set_out(set_out),
        .way_sel(way_sel),
        .data_in_sel(data_in_sel),
        .write_en(write_en),
        .load_tag(load_tag),
        .cacheline_read(cacheline_read),
        .cacheline_write(cacheline_write),
        .cacheline_resp(cacheline_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic all_outs_zero(input string tag);
        chk(tag, {15'd0, resp, set_out, way_sel, data_in_sel, write_en,
                  load_tag, cacheline_read, cacheline_write}, 32'd0);
    endtask

    task automatic do_hit(input bit wr, input logic [2:0] s,
                          input logic [3:0] c, input int way, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << way;
        mem_read = !wr;
        mem_write = wr;
        set_in = s;
        cmp = c;
        @(negedge clk);
        chk({tag, " resp"}, resp, 1);
        chk({tag, " way_sel"}, way_sel, way);
        chk({tag, " write_en"}, write_en, wr ? oh : 4'b0000);
        cyc();
        mem_read = 1'b0;
        mem_write = 1'b0;
        cmp = '0;
    endtask

    task automatic do_miss(input bit wr, input logic [2:0] s, input logic [3:0] c,
                           input int way, input bit wb, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << way;
        mem_read = !wr;
        mem_write = wr;
        set_in = s;
        cmp = c;
        @(negedge clk);
        chk({tag, " idle resp"}, resp, 0);
        cyc();
        if (wb) begin
            @(negedge clk);
            chk({tag, " wb write"}, cacheline_write, 1);
            chk({tag, " wb way_sel"}, way_sel, way);
            chk({tag, " wb read"}, cacheline_read, 0);
            cyc();
            cacheline_resp = 1'b1;
            @(negedge clk);
            chk({tag, " wb hold"}, cacheline_write, 1);
            cyc();
            cacheline_resp = 1'b0;
        end
        @(negedge clk);
        chk({tag, " load_tag"}, load_tag, oh);
        chk({tag, " set_out"}, set_out, s);
        cyc();
        @(negedge clk);
        chk({tag, " cl_read"}, cacheline_read, 1);
        chk({tag, " fill we"}, write_en, oh);
        chk({tag, " fill sel"}, data_in_sel, 1);
        cyc();
        cacheline_resp = 1'b1;
        @(negedge clk);
        chk({tag, " cl_read hold"}, cacheline_read, 1);
        cyc();
        cacheline_resp = 1'b0;
        @(negedge clk);
        chk({tag, " done resp"}, resp, 1);
        chk({tag, " done cl_read"}, cacheline_read, 0);
        chk({tag, " done we"}, write_en, wr ? oh : 4'b0000);
        chk({tag, " done sel"}, data_in_sel, 0);
        cyc();
        mem_read = 1'b0;
        mem_write = 1'b0;
        cmp = '0;
    endtask

`ifdef L2_FLUSH_EN
    task automatic do_flush(input int exp_bursts, input int exp_cycles,
                            input string tag);
        int bursts;
        int n;
        bit done;
        bit prev_wr;
        logic [4:0] loc [2];
        bursts = 0;
        n = 0;
        done = 1'b0;
        prev_wr = 1'b0;
        loc[0] = '0;
        loc[1] = '0;
        mem_read = 1'b1;
        mem_write = 1'b1;
        @(negedge clk);
        chk({tag, " req resp"}, resp, 0);
        while (!done && n < 300) begin
            cyc();
            n++;
            cacheline_resp = prev_wr && !cacheline_resp;
            @(negedge clk);
            if (resp) begin
                done = 1'b1;
            end else if (cacheline_write && !prev_wr) begin
                if (bursts < 2) loc[bursts] = {set_out, way_sel};
                bursts++;
            end
            prev_wr = cacheline_write;
        end
        cacheline_resp = 1'b0;
        chk({tag, " finished"}, done, 1);
        chk({tag, " bursts"}, bursts, exp_bursts);
        chk({tag, " cycles"}, n, exp_cycles);
        if (exp_bursts == 2) begin
            chk({tag, " wb0 loc"}, loc[0], {3'd2, 2'd0});
            chk({tag, " wb1 loc"}, loc[1], {3'd7, 2'd0});
        end
        cyc();
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask
`endif

    initial begin
        int act;
        repeat (2) cyc();
        @(negedge clk);
        all_outs_zero("reset outs");
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        all_outs_zero("idle outs");
        cyc();

        do_miss(0, 3'd3, 4'b0000, 0, 0, "miss3 w0");
        do_miss(0, 3'd3, 4'b0000, 1, 0, "miss3 w1");
        do_miss(0, 3'd3, 4'b0000, 2, 0, "miss3 w2");
        do_miss(0, 3'd3, 4'b0000, 3, 0, "miss3 w3");
        do_hit(0, 3'd3, 4'b0001, 0, "rd hit w0");
        do_miss(0, 3'd3, 4'b0000, 2, 0, "plru victim2");
        do_hit(1, 3'd3, 4'b0010, 1, "wr hit w1");
        do_hit(0, 3'd3, 4'b0001, 0, "rd hit w0b");
        do_hit(0, 3'd3, 4'b1000, 3, "rd hit w3");
        do_miss(0, 3'd3, 4'b0000, 1, 1, "dirty victim1");
        do_miss(0, 3'd3, 4'b0000, 2, 0, "clean victim2");

        do_miss(1, 3'd5, 4'b0000, 0, 0, "wr miss5");
        do_miss(0, 3'd5, 4'b0000, 1, 0, "miss5 w1");
        do_miss(0, 3'd5, 4'b0000, 2, 0, "miss5 w2");
        do_miss(0, 3'd5, 4'b0000, 3, 0, "miss5 w3");
        do_miss(0, 3'd5, 4'b0000, 0, 1, "wr fill dirty");

        mem_read = 1'b1;
        set_in = 3'd6;
        cmp = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("pre-rst cl_read", cacheline_read, 1);
        cyc();
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst cl_read", cacheline_read, 0);
        chk("rst resp", resp, 0);
        cyc();
        rst_n = 1'b1;
        mem_read = 1'b0;
        cyc();
        do_miss(0, 3'd3, 4'b0001, 0, 0, "post rst");

`ifdef L2_FLUSH_EN
        do_miss(1, 3'd2, 4'b0000, 0, 0, "dirty s2");
        do_miss(1, 3'd7, 4'b0000, 0, 0, "dirty s7");
        do_flush(2, 37, "flush dirty");
        do_flush(0, 33, "flush clean");
        do_hit(0, 3'd2, 4'b0001, 0, "valid kept");
`else
        act = 0;
        mem_read = 1'b1;
        mem_write = 1'b1;
        set_in = 3'd3;
        cmp = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp || cacheline_read || cacheline_write ||
                (|write_en) || (|load_tag)) act++;
            cyc();
        end
        chk("rw ignored", act, 0);
        mem_read = 1'b0;
        mem_write = 1'b0;
        cmp = '0;
        cyc();
        do_hit(0, 3'd3, 4'b0001, 0, "after rw");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
